rs_select: RTL and testbench
============================

// Module: rs_select
// PURPOSE
//  Reservation station and select stage directly upstream of issue.
//  - Buffers renamed instructions (res_entry) and tracks source-operand readiness.
//  - Wakes entries from completion tag broadcasts.
//  - Each cycle picks the oldest ready entry per functional-unit lane:
//    lanes 0/1 = ALU (R/I type), lane 2 = MEM (LW/SW).
//  - Drives line_1..line_3 and func_units[2:0] into issue.
// PARAMETERS
//  DEPTH     8   entries in the station (power of two, 4..16)
//  TAG_W     6   physical register tag width (64-entry register_file)
// PORTS
//  clk           in   1          rising-edge clock
//  rst_n         in   1          asynchronous active-low reset
//  flush         in   1          synchronous: invalidate all entries
//  in_valid      in   1          rename offers in_entry
//  in_ready      out  1          station can accept this cycle
//  in_entry      in   res_entry  renamed instruction (opcode, alu_op, rs1, rs2, rd, imm)
//  in_rs1_rdy    in   1          rs1 value already present in register_file
//  in_rs2_rdy    in   1          rs2 value already present in register_file
//  wb_valid      in   3          completion broadcast valid, one bit per FU
//  wb_tag        in   3xTAG_W    destination tags being written this cycle
//  fu_free       in   3          FU lane n can take an instruction next cycle
//  line_1..3     out  res_entry  selected entry for lane 0/1/2 (registered)
//  func_units    out  3          lane n carries a valid instruction (registered)
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous):
//  - All entries invalid; age matrix cleared.
//  - func_units=0, line_1..3=0.
//  - in_ready=1 once reset is released.
//  Classes, decoded from opcode:
//  - ALU: 0110011 or 0010011.
//  - MEM: 0000011 or 0100011.
//  - rs2 is used only by 0110011 and 0100011; for all other classes rs2 readiness is forced to 1.
//  - Any other opcode completes the handshake but is discarded (never written).
//  Insert:
//  - Accepted when in_valid & in_ready.
//  - in_ready = (valid count < DEPTH), computed from registered state only; same-cycle issue frees do not count.
//  - Written into the lowest-index free slot.
//  - src ready = in_rsN_rdy OR (any wb_valid[k] & wb_tag[k]==rsN) in the same cycle (wakeup bypass).
//  Wakeup:
//  - For every valid entry and each k, wb_valid[k] & wb_tag[k]==rsN sets rdyN at the edge.
//  - All three tags are applied in the same cycle.
//  Age:
//  - DEPTH x DEPTH matrix.
//  - Insert at slot i sets age[i][j]=valid[j] ("j older than i") and clears column i.
//  - Freeing slot j clears column j.
//  Select (combinational on registered state):
//  - Candidate = valid & rdy1 & rdy2 & correct class.
//  - Lane 0 takes the oldest ALU candidate, if fu_free[0].
//  - Lane 1 takes the oldest ALU candidate excluding lane 0's pick, if fu_free[1].
//  - Lane 2 takes the oldest MEM candidate, if fu_free[2].
//  - No candidate, or FU busy: that lane's func_units bit = 0 and its line_n holds its previous value.
//  Issue edge:
//  - Selected entries are registered onto line_n, func_units[n]=1, and the slot is freed, all at the same edge.
//  - Latency: an instruction inserted at edge t is eligible at edge t+1 at the earliest.
//  - An entry is never issued twice; func_units is a one-cycle pulse per issued instruction.
//  Simultaneous insert + issue: allowed. The freed slot is reusable one cycle later.
//  flush:
//  - Has priority over insert, wakeup and issue.
//  - Next cycle: all entries invalid and func_units=0.
//  - An insert in the flush cycle is dropped.
//  Reset asserted mid-operation: immediate return to the reset state; no partial issue.
// STRUCTURE
//  respackage additions:
//  - OPC_RTYPE, OPC_ITYPE, OPC_LOAD, OPC_STORE constants.
//  - rs_class_e {CLS_ALU, CLS_MEM, CLS_NONE}.
//  - function uses_rs2(opcode).
//  Sub-module rs_age_picker:
//  - Parameter DEPTH; inputs req[DEPTH] and age matrix; output one-hot grant and any.
//  - Instantiated three times; lane 1 req is masked by lane 0 grant.
// TESTING
//  1 Reset, insert ADD with both rdy=1, all fu_free=1.
//    -> func_units=001 one cycle after the insert edge; line_1 == entry; station empty after.
//  2 Insert ADDI (rs1=5, rdy=0), then pulse wb_valid=001, wb_tag[0]=5.
//    -> issues on lane 0 the cycle after the wakeup edge.
//  3 Insert ADD A, ADD B, LW C, all ready.
//    -> one cycle later func_units=111: line_1=A (oldest), line_2=B, line_3=C.
//  4 Fill 8 ready ALU entries with fu_free=000.
//    -> in_ready=0, a 9th in_valid is not accepted.
//    Then fu_free=011.
//    -> two oldest issue per cycle; in_ready=1 the cycle after the first issue.
//  5 Insert SW with rs2 not ready, wb_tag broadcast in the same cycle as the insert.
//    -> bypass sets ready; issues on lane 2 next cycle.
//  6 Flush with 5 valid entries plus a concurrent insert.
//    -> next cycle func_units=000, count=0, in_ready=1.
//    Mid-run rst_n=0.
//    -> func_units=0 asynchronously.

Source files
------------

// File: rtl/rs_select_pkg.sv
// Shared types for the reservation station: opcode classes, the renamed entry
// layout and small opcode decode helpers.
package rs_select_pkg;

  localparam int RS_TAG_W = 6;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_MEM,
    CLS_NONE
  } rs_class_e;

  typedef struct packed {
    logic [6:0]          opcode;
    logic [3:0]          alu_op;
    logic [RS_TAG_W-1:0] rs1;
    logic [RS_TAG_W-1:0] rs2;
    logic [RS_TAG_W-1:0] rd;
    logic [11:0]         imm;
  } res_entry;

  function automatic rs_class_e rs_class(input logic [6:0] opcode);
    rs_class_e cls;
    case (opcode)
      OPC_RTYPE, OPC_ITYPE: cls = CLS_ALU;
      OPC_LOAD, OPC_STORE:  cls = CLS_MEM;
      default:              cls = CLS_NONE;
    endcase
    return cls;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OPC_RTYPE) || (opcode == OPC_STORE);
  endfunction

endpackage

// File: rtl/rs_select_age_picker.sv
// Oldest-first picker: grants the requester that has no older requester,
// where age[i][j] = 1 means slot j is older than slot i.
module rs_age_picker #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]            req,
  input  logic [DEPTH-1:0][DEPTH-1:0] age,
  output logic [DEPTH-1:0]            grant,
  output logic                        any
);

  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = req[i] & ~(|(req & age[i]));
    end
  end

  assign any = |req;

endmodule

// File: rtl/rs_select.sv
// Reservation station with tag wakeup and per-lane oldest-ready select,
// feeding two ALU lanes and one MEM lane into issue.
module rs_select
  import rs_select_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = RS_TAG_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  res_entry              in_entry,
  input  logic                  in_rs1_rdy,
  input  logic                  in_rs2_rdy,
  input  logic [2:0]            wb_valid,
  input  logic [2:0][TAG_W-1:0] wb_tag,
  input  logic [2:0]            fu_free,
  output res_entry              line_1,
  output res_entry              line_2,
  output res_entry              line_3,
  output logic [2:0]            func_units
);

  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0]            rdy1_q;
  logic [DEPTH-1:0]            rdy2_q;
  logic [DEPTH-1:0][DEPTH-1:0] age_q;
  logic [DEPTH-1:0][DEPTH-1:0] age_d;
  res_entry                    ent_q [DEPTH];
  rs_class_e                   cls_q [DEPTH];

  rs_class_e        in_cls;
  logic             do_ins;
  logic [DEPTH-1:0] free_oh;
  logic [DEPTH-1:0] ins_vec;
  logic             byp1;
  logic             byp2;
  logic [DEPTH-1:0] wake1;
  logic [DEPTH-1:0] wake2;
  logic [DEPTH-1:0] alu_cand;
  logic [DEPTH-1:0] mem_cand;
  logic [DEPTH-1:0] req0, req1, req2;
  logic [DEPTH-1:0] gnt0, gnt1, gnt2;
  logic             any0, any1, any2;
  logic [DEPTH-1:0] freed;
  res_entry         sel0, sel1, sel2;

  function automatic logic tag_hit(input logic [2:0]            v,
                                   input logic [2:0][TAG_W-1:0] t,
                                   input logic [TAG_W-1:0]      tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hit = hit | (v[k] & (t[k] == tag));
    end
    return hit;
  endfunction

  // Full-ness uses registered valids only, so a same-cycle issue never opens a slot early.
  assign in_ready = ~(&vld_q);
  assign in_cls   = rs_class(in_entry.opcode);
  assign do_ins   = in_valid & in_ready & (in_cls != CLS_NONE) & ~flush;
  assign free_oh  = ~vld_q & (vld_q + DEPTH'(1));
  assign ins_vec  = do_ins ? free_oh : '0;
  assign byp1     = in_rs1_rdy | tag_hit(wb_valid, wb_tag, in_entry.rs1);
  assign byp2     = ~uses_rs2(in_entry.opcode) | in_rs2_rdy |
                    tag_hit(wb_valid, wb_tag, in_entry.rs2);

  always_comb begin
    wake1    = '0;
    wake2    = '0;
    alu_cand = '0;
    mem_cand = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wake1[i]    = tag_hit(wb_valid, wb_tag, ent_q[i].rs1);
      wake2[i]    = tag_hit(wb_valid, wb_tag, ent_q[i].rs2);
      alu_cand[i] = vld_q[i] & rdy1_q[i] & rdy2_q[i] & (cls_q[i] == CLS_ALU);
      mem_cand[i] = vld_q[i] & rdy1_q[i] & rdy2_q[i] & (cls_q[i] == CLS_MEM);
    end
  end

  assign req0 = alu_cand & {DEPTH{fu_free[0]}};
  assign req1 = alu_cand & ~gnt0 & {DEPTH{fu_free[1]}};
  assign req2 = mem_cand & {DEPTH{fu_free[2]}};

  rs_age_picker #(.DEPTH(DEPTH)) u_pick0 (.req(req0), .age(age_q), .grant(gnt0), .any(any0));
  rs_age_picker #(.DEPTH(DEPTH)) u_pick1 (.req(req1), .age(age_q), .grant(gnt1), .any(any1));
  rs_age_picker #(.DEPTH(DEPTH)) u_pick2 (.req(req2), .age(age_q), .grant(gnt2), .any(any2));

  assign freed = gnt0 | gnt1 | gnt2;

  always_comb begin
    sel0 = '0;
    sel1 = '0;
    sel2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (gnt0[i]) sel0 = ent_q[i];
      if (gnt1[i]) sel1 = ent_q[i];
      if (gnt2[i]) sel2 = ent_q[i];
    end
  end

  // A new entry is younger than everything still resident after this edge's frees.
  always_comb begin
    age_d = age_q;
    for (int r = 0; r < DEPTH; r++) begin
      for (int c = 0; c < DEPTH; c++) begin
        if (freed[c] || ins_vec[c]) age_d[r][c] = 1'b0;
      end
      if (ins_vec[r]) age_d[r] = vld_q & ~freed;
    end
  end

  // ---- issue / state update stage boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      rdy1_q     <= '0;
      rdy2_q     <= '0;
      age_q      <= '0;
      func_units <= '0;
      line_1     <= '0;
      line_2     <= '0;
      line_3     <= '0;
    end else if (flush) begin
      vld_q      <= '0;
      age_q      <= '0;
      func_units <= '0;
    end else begin
      vld_q      <= (vld_q & ~freed) | ins_vec;
      age_q      <= age_d;
      func_units <= {any2, any1, any0};
      for (int i = 0; i < DEPTH; i++) begin
        rdy1_q[i] <= ins_vec[i] ? byp1 : (rdy1_q[i] | wake1[i]);
        rdy2_q[i] <= ins_vec[i] ? byp2 : (rdy2_q[i] | wake2[i]);
      end
      if (any0) line_1 <= sel0;
      if (any1) line_2 <= sel1;
      if (any2) line_3 <= sel2;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (ins_vec[i]) begin
        ent_q[i] <= in_entry;
        cls_q[i] <= in_cls;
      end
    end
  end

endmodule

// File: tb/tb_rs_select.sv
// Directed bench for rs_select: insert/issue latency, wakeup, age order,
// full back-pressure, bypass, flush and asynchronous reset.
module tb_rs_select;
  import rs_select_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  res_entry        in_entry;
  logic            in_rs1_rdy;
  logic            in_rs2_rdy;
  logic [2:0]      wb_valid;
  logic [2:0][5:0] wb_tag;
  logic [2:0]      fu_free;
  res_entry        line_1, line_2, line_3;
  logic [2:0]      func_units;

  int checks = 0;
  int fails  = 0;

  rs_select #(.DEPTH(8), .TAG_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_entry(in_entry), .in_rs1_rdy(in_rs1_rdy), .in_rs2_rdy(in_rs2_rdy),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .fu_free(fu_free),
    .line_1(line_1), .line_2(line_2), .line_3(line_3), .func_units(func_units)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_entry mk(input logic [6:0] opc, input logic [5:0] r1,
                                  input logic [5:0] r2, input logic [5:0] rd,
                                  input logic [11:0] imm);
    res_entry e;
    e.opcode = opc;
    e.alu_op = 4'h0;
    e.rs1    = r1;
    e.rs2    = r2;
    e.rd     = rd;
    e.imm    = imm;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input res_entry e, input logic r1, input logic r2);
    in_valid   = 1'b1;
    in_entry   = e;
    in_rs1_rdy = r1;
    in_rs2_rdy = r2;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if (func_units !== 3'b000) begin $display("FAIL reset_fu actual=%b expected=000", func_units); fails++; end
    checks++;
    if ({line_1, line_2, line_3} !== '0) begin $display("FAIL reset_lines actual=%h expected=0", {line_1, line_2, line_3}); fails++; end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready actual=%b expected=1", in_ready); fails++; end
  endtask

  task automatic test_basic_issue();
    res_entry a;
    a = mk(OPC_RTYPE, 6'd1, 6'd2, 6'd3, 12'h000);
    fu_free = 3'b111;
    offer(a, 1'b1, 1'b1);
    checks++;
    if (func_units !== 3'b000) begin $display("FAIL t1_no_early_issue actual=%b expected=000", func_units); fails++; end
    tick();
    checks++;
    if (func_units !== 3'b001) begin $display("FAIL t1_fu actual=%b expected=001", func_units); fails++; end
    checks++;
    if (line_1 !== a) begin $display("FAIL t1_line1 actual=%h expected=%h", line_1, a); fails++; end
    tick();
    checks++;
    if (func_units !== 3'b000) begin $display("FAIL t1_pulse actual=%b expected=000", func_units); fails++; end
  endtask

  task automatic test_wakeup();
    res_entry a;
    a = mk(OPC_ITYPE, 6'd5, 6'd0, 6'd7, 12'h123);
    offer(a, 1'b0, 1'b0);
    tick();
    checks++;
    if (func_units !== 3'b000) begin $display("FAIL t2_waiting actual=%b expected=000", func_units); fails++; end
    wb_valid  = 3'b001;
    wb_tag[0] = 6'd5;
    tick();
    wb_valid = 3'b000;
    checks++;
    if (func_units !== 3'b000) begin $display("FAIL t2_wake_edge actual=%b expected=000", func_units); fails++; end
    tick();
    checks++;
    if (func_units !== 3'b001) begin $display("FAIL t2_fu actual=%b expected=001", func_units); fails++; end
    checks++;
    if (line_1 !== a) begin $display("FAIL t2_line1 actual=%h expected=%h", line_1, a); fails++; end
  endtask

  task automatic test_three_lanes();
    res_entry a, b, c;
    a = mk(OPC_RTYPE, 6'd10, 6'd11, 6'd12, 12'h001);
    b = mk(OPC_RTYPE, 6'd13, 6'd14, 6'd15, 12'h002);
    c = mk(OPC_LOAD,  6'd16, 6'd0,  6'd17, 12'h004);
    fu_free = 3'b000;
    offer(a, 1'b1, 1'b1);
    offer(b, 1'b1, 1'b1);
    offer(c, 1'b1, 1'b0);
    fu_free = 3'b111;
    tick();
    checks++;
    if (func_units !== 3'b111) begin $display("FAIL t3_fu actual=%b expected=111", func_units); fails++; end
    checks++;
    if (line_1 !== a) begin $display("FAIL t3_line1 actual=%h expected=%h", line_1, a); fails++; end
    checks++;
    if (line_2 !== b) begin $display("FAIL t3_line2 actual=%h expected=%h", line_2, b); fails++; end
    checks++;
    if (line_3 !== c) begin $display("FAIL t3_line3 actual=%h expected=%h", line_3, c); fails++; end
    tick();
    checks++;
    if (func_units !== 3'b000) begin $display("FAIL t3_pulse actual=%b expected=000", func_units); fails++; end
  endtask

  task automatic test_full_back_to_back();
    res_entry e [9];
    for (int i = 0; i < 9; i++) e[i] = mk(OPC_RTYPE, 6'd20, 6'd21, 6'(30 + i), 12'(i));
    fu_free = 3'b000;
    for (int i = 0; i < 8; i++) offer(e[i], 1'b1, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin $display("FAIL t4_full actual=%b expected=0", in_ready); fails++; end
    offer(e[8], 1'b1, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin $display("FAIL t4_still_full actual=%b expected=0", in_ready); fails++; end
    fu_free = 3'b011;
    for (int p = 0; p < 4; p++) begin
      tick();
      checks++;
      if (func_units !== 3'b011) begin $display("FAIL t4_fu_%0d actual=%b expected=011", p, func_units); fails++; end
      checks++;
      if (line_1 !== e[2*p]) begin $display("FAIL t4_line1_%0d actual=%h expected=%h", p, line_1, e[2*p]); fails++; end
      checks++;
      if (line_2 !== e[2*p+1]) begin $display("FAIL t4_line2_%0d actual=%h expected=%h", p, line_2, e[2*p+1]); fails++; end
      if (p == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin $display("FAIL t4_ready_after_issue actual=%b expected=1", in_ready); fails++; end
      end
    end
    tick();
    checks++;
    if (func_units !== 3'b000) begin $display("FAIL t4_ninth_dropped actual=%b expected=000", func_units); fails++; end
  endtask

  task automatic test_bypass_and_discard();
    res_entry s, br;
    s  = mk(OPC_STORE, 6'd40, 6'd9, 6'd0, 12'h010);
    br = mk(7'b1100011, 6'd1, 6'd2, 6'd0, 12'h020);
    fu_free   = 3'b111;
    wb_valid  = 3'b010;
    wb_tag[1] = 6'd9;
    offer(s, 1'b1, 1'b0);
    wb_valid = 3'b000;
    checks++;
    if (func_units !== 3'b000) begin $display("FAIL t5_insert_edge actual=%b expected=000", func_units); fails++; end
    tick();
    checks++;
    if (func_units !== 3'b100) begin $display("FAIL t5_fu actual=%b expected=100", func_units); fails++; end
    checks++;
    if (line_3 !== s) begin $display("FAIL t5_line3 actual=%h expected=%h", line_3, s); fails++; end
    offer(br, 1'b1, 1'b1);
    tick();
    checks++;
    if (func_units !== 3'b000) begin $display("FAIL t5_discard actual=%b expected=000", func_units); fails++; end
  endtask

  task automatic test_flush();
    fu_free = 3'b000;
    for (int i = 0; i < 5; i++) offer(mk(OPC_RTYPE, 6'd1, 6'd2, 6'(i), 12'h0), 1'b1, 1'b1);
    fu_free    = 3'b111;
    flush      = 1'b1;
    in_valid   = 1'b1;
    in_entry   = mk(OPC_LOAD, 6'd3, 6'd0, 6'd4, 12'h0);
    in_rs1_rdy = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (func_units !== 3'b000) begin $display("FAIL t6_flush_fu actual=%b expected=000", func_units); fails++; end
    checks++;
    if (in_ready !== 1'b1) begin $display("FAIL t6_flush_ready actual=%b expected=1", in_ready); fails++; end
    tick();
    checks++;
    if (func_units !== 3'b000) begin $display("FAIL t6_empty actual=%b expected=000", func_units); fails++; end
  endtask

  task automatic test_async_reset();
    res_entry x, y;
    x = mk(OPC_RTYPE, 6'd50, 6'd51, 6'd52, 12'h0AA);
    y = mk(OPC_RTYPE, 6'd53, 6'd54, 6'd55, 12'h0BB);
    fu_free = 3'b000;
    offer(x, 1'b1, 1'b1);
    offer(y, 1'b1, 1'b1);
    fu_free = 3'b001;
    tick();
    checks++;
    if (func_units !== 3'b001) begin $display("FAIL t7_pre_reset actual=%b expected=001", func_units); fails++; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (func_units !== 3'b000) begin $display("FAIL t7_async_fu actual=%b expected=000", func_units); fails++; end
    checks++;
    if (line_1 !== '0) begin $display("FAIL t7_async_line1 actual=%h expected=0", line_1); fails++; end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (func_units !== 3'b000) begin $display("FAIL t7_no_partial_issue actual=%b expected=000", func_units); fails++; end
    checks++;
    if (in_ready !== 1'b1) begin $display("FAIL t7_ready actual=%b expected=1", in_ready); fails++; end
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_entry   = '0;
    in_rs1_rdy = 1'b0;
    in_rs2_rdy = 1'b0;
    wb_valid   = 3'b000;
    wb_tag     = '0;
    fu_free    = 3'b111;
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_three_lanes();
    test_full_back_to_back();
    test_bypass_and_discard();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
